load_align_unit: RTL and testbench
==================================

// Module: load_align_unit
// PURPOSE
//  Multicycle load path between memory and register write-back: accepts a load request (address, size, signedness),
//  issues one or two aligned memory reads, extracts the addressed bytes, and sign- or zero-extends them.
//  Generalises the fixed word/half/byte zero-extend load helper: byte offsets, signed loads, a 64-bit datapath,
//  word-crossing accesses, and a ready/valid handshake on both sides.
// PARAMETERS
//  DATA_W     32  memory/result width; legal values 32 or 64. NB = DATA_W/8; OFF_W = log2(NB).
//  ADDR_W     32  byte address width.
//  MISALIGN   0   0 = misaligned access returns an error response; 1 = split into two reads and merge.
// PORTS
//  clk         in   1       clock, rising edge.
//  reset       in   1       asynchronous, active-low reset.
//  req_valid   in   1       load request present.
//  req_ready   out  1       high only in IDLE.
//  req_addr    in   ADDR_W  byte address.
//  req_size    in   2       00=4B, 01=2B, 10=1B, 11=8B (8B legal only if DATA_W=64).
//  req_signed  in   1       1 = sign-extend, 0 = zero-extend.
//  mem_rd_en   out  1       one-cycle read strobe.
//  mem_addr    out  ADDR_W  aligned read address (low OFF_W bits = 0).
//  mem_rdata   in   DATA_W  read data, valid the cycle after mem_rd_en (synchronous RAM).
//  rsp_valid   out  1       result available; held until accepted.
//  rsp_ready   in   1       consumer accepts the result.
//  rsp_data    out  DATA_W  extended result.
//  rsp_err     out  1       qualifies rsp_valid: misaligned (MISALIGN=0) or illegal size; rsp_data=0.
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1, mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0; buffers cleared.
//  Byte lanes are little-endian: byte k of a memory word = rdata[8k+7:8k].
//  Accept on req_valid&&req_ready edge: latch addr, size, signed; off=addr[OFF_W-1:0]; n=bytes(size).
//  Illegal (size 11 with DATA_W=32) -> ERR. Misaligned (off % n != 0) with MISALIGN=0 -> ERR. Otherwise -> RD0.
//  FSM states: IDLE, RD0, CAP0, CAP1, RESP, ERR.
//   RD0 : mem_rd_en=1, mem_addr={addr[ADDR_W-1:OFF_W],0}. -> CAP0.
//   CAP0: buf0<=mem_rdata. If off+n>NB (crossing, only reachable with MISALIGN=1), assert mem_rd_en,
//         mem_addr=first+NB (wraps modulo 2^ADDR_W), and go to CAP1. Otherwise go to RESP.
//   CAP1: buf1<=mem_rdata (buf1=0 when not crossing) -> RESP.
//   RESP: rsp_data = ext(({buf1,buf0} >> 8*off)[8n-1:0]), registered on entry; rsp_valid=1, rsp_err=0.
//         The result is held stable until rsp_ready, then -> IDLE.
//   ERR : rsp_valid=1, rsp_err=1, rsp_data=0; no memory read issued; -> IDLE on rsp_ready.
//  ext: if req_signed, replicate bit 8n-1 up to DATA_W; otherwise zero-fill. Size n=NB never extends.
//  Latency from the accept edge to rsp_valid high: 3 cycles aligned/non-crossing, 4 cycles crossing, 1 cycle ERR.
//  rsp_ready already high on the first RESP cycle: the response completes that cycle; req_ready rises the next cycle.
//  Requests are not queued: req_ready=0 outside IDLE. rsp_ready is ignored outside RESP/ERR.
//  Reset mid-operation: immediate return to reset values; any in-flight read data is discarded.
//  Outputs are registered; mem_rd_en never stays high for two consecutive cycles except CAP0 following RD0.
// TESTING
//  T1 DATA_W=32: mem[0x100]=0x8899AABB; byte load @0x102, signed -> rsp_data=0xFFFFFF99, rsp_valid 3 cycles after accept.
//  T2 same word, half @0x102, unsigned -> 0x00008899; signed -> 0xFFFF8899; word @0x100 -> 0x8899AABB.
//  T3 MISALIGN=1: mem[0x100]=0x44332211, mem[0x104]=0x88776655; word @0x103 -> 0x77665544, mem_addr 0x100 then 0x104, 4-cycle latency.
//  T4 MISALIGN=0: half @0x101 -> rsp_valid & rsp_err 1 cycle after accept, rsp_data=0, mem_rd_en never asserted.
//  T5 rsp_ready held low 5 cycles in RESP: rsp_valid and rsp_data stable, req_ready=0, new req_valid not accepted.
//  T6 reset asserted low in CAP0: next cycle all outputs at reset values; a following byte load @0x100 returns 0x11.

Source files
------------

// File: rtl/load_align_unit.sv
// load_align_unit
//   Multicycle load path between a synchronous memory and register write-back.
//   A request (byte address, size, signedness) is accepted in IDLE. The unit issues
//   one aligned read, or two when the access crosses a word boundary and MISALIGN=1.
//   It then extracts the addressed little-endian bytes and sign- or zero-extends them.
//   Misaligned accesses with MISALIGN=0, and 8-byte loads on a 32-bit datapath,
//   return an error response instead.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   req_valid   request present; accepted when req_ready is high
//   req_ready   high only while idle
//   req_addr    byte address of the load
//   req_size    00=4B, 01=2B, 10=1B, 11=8B
//   req_signed  1 = sign-extend, 0 = zero-extend
//   mem_rd_en   one-cycle read strobe
//   mem_addr    word-aligned read address
//   mem_rdata   read data, valid the cycle after mem_rd_en
//   rsp_valid   response present; held until rsp_ready
//   rsp_ready   consumer accepts the response
//   rsp_data    extended load result (0 on error)
//   rsp_err     response is an error (misaligned or illegal size)
module load_align_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MISALIGN = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [2:0] {IDLE, RD0, CAP0, CAP1, RESP, ERR} state_t;
    state_t state, next_state;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [DATA_W-1:0] buf0, buf1;

    logic              req_ready_nxt, mem_rd_en_nxt, rsp_valid_nxt, rsp_err_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] rsp_data_nxt;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 4'd4;
            2'b01:   return 4'd2;
            2'b10:   return 4'd1;
            default: return 4'd8;
        endcase
    endfunction

    // Shift the two-word window down to the addressed byte, keep 8n bits and extend.
    // A full-width load (n == NB) has nothing left to extend.
    function automatic logic [DATA_W-1:0] align_ext(input logic [2*DATA_W-1:0] pair,
                                                    input logic [OFF_W-1:0]    off,
                                                    input logic [1:0]          size,
                                                    input logic                sgn);
        logic [2*DATA_W-1:0] shifted;
        logic [DATA_W-1:0]   res;
        logic                fill;
        int                  nbits;
        shifted = pair >> {off, 3'b000};
        nbits   = 8 * int'(size_bytes(size));
        if (nbits > DATA_W) nbits = DATA_W;
        fill = sgn & shifted[nbits-1];
        for (int i = 0; i < DATA_W; i++) res[i] = (i < nbits) ? shifted[i] : fill;
        return res;
    endfunction

    logic [OFF_W-1:0] req_off, off_q;
    logic [3:0]       req_n, n_q;
    logic [4:0]       end_q;
    logic             req_illegal, req_misaligned, crossing;

    assign req_off        = req_addr[OFF_W-1:0];
    assign req_n          = size_bytes(req_size);
    assign req_illegal    = (req_size == 2'b11) && (DATA_W == 32);
    // Sizes are powers of two, so off % n is just the low bits of off.
    assign req_misaligned = ((4'(req_off) & (req_n - 4'd1)) != 4'd0);

    assign off_q    = addr_q[OFF_W-1:0];
    assign n_q      = size_bytes(size_q);
    assign end_q    = 5'(off_q) + 5'(n_q);
    assign crossing = (end_q > 5'(NB));

    // Words are merged on the RESP-entry edge, so the word arriving in that same
    // cycle is taken straight from mem_rdata rather than from its buffer.
    logic [DATA_W-1:0] lo_src, hi_src;
    assign lo_src = (state == CAP0) ? mem_rdata : buf0;
    assign hi_src = (state == CAP1) ? mem_rdata : buf1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= next_state;
            req_ready <= req_ready_nxt;
            mem_rd_en <= mem_rd_en_nxt;
            mem_addr  <= mem_addr_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_illegal || (req_misaligned && (MISALIGN == 0))) next_state = ERR;
                    else                                                    next_state = RD0;
                end
            end
            RD0:     next_state = CAP0;
            CAP0:    next_state = crossing ? CAP1 : RESP;
            CAP1:    next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            ERR:     if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered: this block computes their values for the coming state.
    always_comb begin
        req_ready_nxt = (next_state == IDLE);
        mem_rd_en_nxt = 1'b0;
        mem_addr_nxt  = mem_addr;
        rsp_valid_nxt = (next_state == RESP) || (next_state == ERR);
        rsp_err_nxt   = (next_state == ERR);
        rsp_data_nxt  = rsp_data;
        if (state == IDLE && next_state == RD0) begin
            mem_rd_en_nxt = 1'b1;
            mem_addr_nxt  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
        // The second read is strobed during CAP0, right behind the first; it wraps at the top.
        if (state == RD0 && crossing) begin
            mem_rd_en_nxt = 1'b1;
            mem_addr_nxt  = mem_addr + ADDR_W'(NB);
        end
        if (next_state == ERR)
            rsp_data_nxt = '0;
        else if (next_state == RESP && state != RESP)
            rsp_data_nxt = align_ext({hi_src, lo_src}, off_q, size_q, signed_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                signed_q <= req_signed;
                buf1     <= '0;
            end
            if (state == CAP0) buf0 <= mem_rdata;
            if (state == CAP1) buf1 <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit.
// Instance a uses MISALIGN=0 and instance b uses MISALIGN=1. Both are 32-bit.
// They share a word memory, and only one of them is exercised at a time.
module tb_load_align_unit;
    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        rsp_ready;
    logic        req_valid_a, req_valid_b;
    logic        req_ready_a, mem_rd_en_a, rsp_valid_a, rsp_err_a;
    logic        req_ready_b, mem_rd_en_b, rsp_valid_b, rsp_err_b;
    logic [31:0] mem_addr_a, mem_rdata_a, rsp_data_a;
    logic [31:0] mem_addr_b, mem_rdata_b, rsp_data_b;

    always #5 clk = ~clk;

    load_align_unit #(.DATA_W(32), .ADDR_W(32), .MISALIGN(0)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .mem_rd_en(mem_rd_en_a), .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_a), .rsp_err(rsp_err_a)
    );

    load_align_unit #(.DATA_W(32), .ADDR_W(32), .MISALIGN(1)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .mem_rd_en(mem_rd_en_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_b), .rsp_err(rsp_err_b)
    );

    // Sparse word memory: only address bits [9:2] select a word.
    logic [31:0] mem [0:255];

    always @(posedge clk) begin
        if (mem_rd_en_a) mem_rdata_a <= mem[mem_addr_a[9:2]];
        if (mem_rd_en_b) mem_rdata_b <= mem[mem_addr_b[9:2]];
    end

    bit          sel;
    bit          chk_en;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [31:0] rd_log[$];
    int          tests, fails;

    logic        cur_req_ready, cur_mem_rd_en, cur_rsp_valid, cur_rsp_err;
    logic [31:0] cur_mem_addr, cur_rsp_data;
    always_comb begin
        cur_req_ready = sel ? req_ready_b : req_ready_a;
        cur_mem_rd_en = sel ? mem_rd_en_b : mem_rd_en_a;
        cur_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
        cur_rsp_err   = sel ? rsp_err_b   : rsp_err_a;
        cur_mem_addr  = sel ? mem_addr_b  : mem_addr_a;
        cur_rsp_data  = sel ? rsp_data_b  : rsp_data_a;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: gather the n addressed bytes one by one and extend.
    function automatic void model(input logic [31:0] addr, input logic [1:0] size,
                                  input logic sgn, input bit mis,
                                  output logic [31:0] d, output logic e,
                                  output int lat, output int nrd);
        int n;
        int off;
        off = int'(addr[1:0]);
        case (size)
            2'b00:   n = 4;
            2'b01:   n = 2;
            2'b10:   n = 1;
            default: n = 8;
        endcase
        d = '0;
        e = 1'b0;
        if (n > NB || (!mis && (off % n) != 0)) begin
            e = 1'b1; lat = 1; nrd = 0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = addr + 32'(i);
            d[8*i +: 8] = mem[a[9:2]][8*a[1:0] +: 8];
        end
        if (sgn && n < 4 && d[8*n-1])
            for (int i = 8*n; i < 32; i++) d[i] = 1'b1;
        if (off + n > NB) begin lat = 4; nrd = 2; end
        else              begin lat = 3; nrd = 1; end
    endfunction

    // Per-cycle compare against the expected response, plus read address logging.
    always @(negedge clk) begin
        if (reset && chk_en) begin
            if (cur_rsp_valid) begin
                check("rsp_data", 64'(cur_rsp_data), 64'(exp_data));
                check("rsp_err", 64'(cur_rsp_err), 64'(exp_err));
                check("req_ready_busy", 64'(cur_req_ready), 64'd0);
            end
            if (cur_mem_rd_en) begin
                check("mem_addr_aligned", 64'(cur_mem_addr[1:0]), 64'd0);
                rd_log.push_back(cur_mem_addr);
            end
        end
    end

    task automatic check_reset_vals(input string nm);
        check({nm, "_req_ready"}, 64'(req_ready_a), 64'd1);
        check({nm, "_mem_rd_en"}, 64'(mem_rd_en_a), 64'd0);
        check({nm, "_mem_addr"},  64'(mem_addr_a),  64'd0);
        check({nm, "_rsp_valid"}, 64'(rsp_valid_a), 64'd0);
        check({nm, "_rsp_data"},  64'(rsp_data_a),  64'd0);
        check({nm, "_rsp_err"},   64'(rsp_err_a),   64'd0);
    endtask

    task automatic do_load(input bit s, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input int hold, input bit use_lit,
                           input logic [31:0] lit, input string nm);
        logic [31:0] d;
        logic        e;
        int          lat, nrd, got;
        model(addr, size, sgn, s, d, e, lat, nrd);
        if (use_lit) check({nm, "_model"}, 64'(d), 64'(lit));
        @(negedge clk);
        sel = s; exp_data = d; exp_err = e; rd_log.delete();
        req_addr = addr; req_size = size; req_signed = sgn;
        rsp_ready = (hold == 0);
        check({nm, "_req_ready_idle"}, 64'(cur_req_ready), 64'd1);
        if (s) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        got = 0;
        for (int k = 1; k <= 8 && got == 0; k++) begin
            @(negedge clk);
            if (cur_rsp_valid) got = k;
        end
        check({nm, "_latency"}, 64'(got), 64'(lat));
        if (got == 0) begin
            reset = 1'b0; @(negedge clk); reset = 1'b1; rsp_ready = 1'b1;
            return;
        end
        // Stall: a stray request must not be accepted while the response is pending.
        for (int i = 0; i < hold; i++) begin
            req_addr = addr + 32'd4;
            if (s) req_valid_b = 1'b1; else req_valid_a = 1'b1;
            @(negedge clk);
            check({nm, "_hold_valid"}, 64'(cur_rsp_valid), 64'd1);
            check({nm, "_hold_data"},  64'(cur_rsp_data),  64'(d));
            check({nm, "_hold_ready"}, 64'(cur_req_ready), 64'd0);
        end
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check({nm, "_done_valid"}, 64'(cur_rsp_valid), 64'd0);
        check({nm, "_done_ready"}, 64'(cur_req_ready), 64'd1);
        check({nm, "_reads"}, 64'(rd_log.size()), 64'(nrd));
    endtask

    initial begin
        tests = 0; fails = 0; sel = 1'b0; chk_en = 1'b0;
        exp_data = '0; exp_err = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        reset = 1'b0; req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_addr = '0; req_size = '0; req_signed = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b1;
        chk_en = 1'b1;

        // Word at 0x100 = 88 99 AA BB (byte 3 .. byte 0)
        mem[32'h100 >> 2] = 32'h8899AABB;
        do_load(0, 32'h102, 2'b10, 1'b1, 0, 1, 32'hFFFFFF99, "T1_byte_s");
        do_load(0, 32'h102, 2'b01, 1'b0, 0, 1, 32'h00008899, "T2_half_u");
        do_load(0, 32'h102, 2'b01, 1'b1, 0, 1, 32'hFFFF8899, "T2_half_s");
        do_load(0, 32'h100, 2'b00, 1'b1, 0, 1, 32'h8899AABB, "T2_word");
        do_load(0, 32'h103, 2'b10, 1'b0, 0, 1, 32'h00000088, "byte3_u");
        do_load(0, 32'h101, 2'b10, 1'b1, 0, 1, 32'hFFFFFFAA, "byte1_s");
        do_load(0, 32'h100, 2'b10, 1'b0, 0, 1, 32'h000000BB, "byte0_u");
        do_load(0, 32'h100, 2'b11, 1'b0, 0, 1, 32'h00000000, "illegal_a");
        do_load(1, 32'h100, 2'b11, 1'b1, 0, 1, 32'h00000000, "illegal_b");
        do_load(0, 32'h101, 2'b01, 1'b0, 0, 1, 32'h00000000, "T4_mis_half");
        do_load(0, 32'h102, 2'b00, 1'b1, 0, 1, 32'h00000000, "mis_word");
        do_load(0, 32'h100, 2'b00, 1'b0, 5, 1, 32'h8899AABB, "T5_stall");

        mem[32'h100 >> 2] = 32'h44332211;
        mem[32'h104 >> 2] = 32'h88776655;
        mem[32'h108 >> 2] = 32'h000000F0;
        do_load(1, 32'h103, 2'b00, 1'b0, 0, 1, 32'h77665544, "T3_cross_word");
        check("T3_rd0_addr", 64'(rd_log.size() > 0 ? rd_log[0] : 32'hDEAD), 64'h100);
        check("T3_rd1_addr", 64'(rd_log.size() > 1 ? rd_log[1] : 32'hDEAD), 64'h104);
        do_load(1, 32'h101, 2'b00, 1'b0, 0, 1, 32'h55443322, "cross_word1");
        do_load(1, 32'h103, 2'b01, 1'b1, 0, 1, 32'h00005544, "cross_half_pos");
        do_load(1, 32'h107, 2'b01, 1'b1, 0, 1, 32'hFFFFF088, "cross_half_neg");
        do_load(1, 32'h104, 2'b00, 1'b0, 0, 1, 32'h88776655, "b_aligned");
        do_load(1, 32'h102, 2'b01, 1'b1, 0, 1, 32'h00004433, "b_half_nocross");

        // Crossing the top of the address space wraps the second read to 0.
        mem[255] = 32'hDDCC0000;
        mem[0]   = 32'h0000BBAA;
        do_load(1, 32'hFFFFFFFE, 2'b00, 1'b0, 0, 1, 32'hBBAADDCC, "wrap_word");
        check("wrap_rd0_addr", 64'(rd_log.size() > 0 ? rd_log[0] : 32'hDEAD), 64'hFFFFFFFC);
        check("wrap_rd1_addr", 64'(rd_log.size() > 1 ? rd_log[1] : 32'hDEAD), 64'h0);

        // Reset asserted while the unit sits in CAP0.
        @(negedge clk);
        sel = 1'b0; req_addr = 32'h100; req_size = 2'b10; req_signed = 1'b0;
        req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("T6_reset");
        reset = 1'b1;
        do_load(0, 32'h100, 2'b10, 1'b0, 0, 1, 32'h00000011, "T6_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
